// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one external ALU between two requesters
// Ports:
//   i_clk, i_reset              clock, asynchronous active-high reset
//   i_reqN_valid/o_reqN_ready   request handshake (N=0,1)
//   i_reqN_a/b/ctrl             request operands and ALU control code
//   o_rspN_valid/i_rspN_ready   response handshake (N=0,1)
//   o_rspN_data/zero            captured ALU result and zero flag
//   o_alu_a/b/ctrl              operands to the shared ALU (from operand registers)
//   i_alu_out/zero              combinational ALU result
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [WIDTH-1:0] i_req0_a,
  input  logic [WIDTH-1:0] i_req0_b,
  input  logic [3:0]       i_req0_ctrl,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [WIDTH-1:0] i_req1_a,
  input  logic [WIDTH-1:0] i_req1_b,
  input  logic [3:0]       i_req1_ctrl,
  output logic             o_rsp0_valid,
  input  logic             i_rsp0_ready,
  output logic [WIDTH-1:0] o_rsp0_data,
  output logic             o_rsp0_zero,
  output logic             o_rsp1_valid,
  input  logic             i_rsp1_ready,
  output logic [WIDTH-1:0] o_rsp1_data,
  output logic             o_rsp1_zero,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [3:0]       o_alu_ctrl,
  input  logic [WIDTH-1:0] i_alu_out,
  input  logic             i_alu_zero
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t r_state, w_next;
  logic r_last, r_gid, r_zero, w_gnt, w_hs;
  logic [WIDTH-1:0] r_a, r_b, r_res;
  logic [3:0] r_ctrl;
  // A tie goes to whichever requester was not served last
  assign w_gnt = (i_req0_valid & i_req1_valid) ? ~r_last : i_req1_valid;
  always_comb begin
    w_next = r_state;
    w_hs = 1'b0;
    o_req0_ready = 1'b0;
    o_req1_ready = 1'b0;
    o_rsp0_valid = 1'b0;
    o_rsp1_valid = 1'b0;
    case (r_state)
      IDLE: begin
        o_req0_ready = ~i_reset & ~w_gnt & i_req0_valid;
        o_req1_ready = ~i_reset & w_gnt & i_req1_valid;
        w_hs = o_req0_ready | o_req1_ready;
        w_next = w_hs ? EXEC : IDLE;
      end
      EXEC: w_next = RESP;
      RESP: begin
        o_rsp0_valid = ~r_gid;
        o_rsp1_valid = r_gid;
        w_next = (r_gid ? i_rsp1_ready : i_rsp0_ready) ? IDLE : RESP;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_last <= 1'b1;
      r_gid <= 1'b0;
      r_a <= '0;
      r_b <= '0;
      r_ctrl <= '0;
      r_res <= '0;
      r_zero <= 1'b1;
    end else begin
      if (w_hs) begin
        r_a <= w_gnt ? i_req1_a : i_req0_a;
        r_b <= w_gnt ? i_req1_b : i_req0_b;
        r_ctrl <= w_gnt ? i_req1_ctrl : i_req0_ctrl;
        r_gid <= w_gnt;
        r_last <= w_gnt;
      end
      if (r_state == EXEC) begin
        r_res <= i_alu_out;
        r_zero <= i_alu_zero;
      end
    end
  end
  assign o_alu_a = r_a;
  assign o_alu_b = r_b;
  assign o_alu_ctrl = r_ctrl;
  assign o_rsp0_data = r_res;
  assign o_rsp1_data = r_res;
  assign o_rsp0_zero = r_zero;
  assign o_rsp1_zero = r_zero;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random checks of alu_arbiter against a transaction-level model
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] v, rr, hs;
  logic [31:0] req_a[2], req_b[2];
  logic [3:0] req_c[2];
  logic rdy0, rdy1, rv0, rv1, rz0, rz1, alu_zero;
  logic [31:0] rd0, rd1, alu_a, alu_b, alu_out;
  logic [3:0] alu_ctrl;
  int n_chk = 0, n_fail = 0;
  logic m_busy, m_last, m_id, m_cnt, g;
  logic [1:0] er, ev;
  logic [31:0] m_a, m_b, m_data;
  logic [3:0] m_c;
  logic q_gnt[$];
  logic [32:0] q_res[$];
  logic [3:0] codes[10] = '{4'b0000, 4'b0010, 4'b0100, 4'b0110, 4'b1110,
                            4'b1000, 4'b1011, 4'b1111, 4'b1010, 4'b1100};

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_req0_valid(v[0]), .o_req0_ready(rdy0), .i_req0_a(req_a[0]), .i_req0_b(req_b[0]), .i_req0_ctrl(req_c[0]),
    .i_req1_valid(v[1]), .o_req1_ready(rdy1), .i_req1_a(req_a[1]), .i_req1_b(req_b[1]), .i_req1_ctrl(req_c[1]),
    .o_rsp0_valid(rv0), .i_rsp0_ready(rr[0]), .o_rsp0_data(rd0), .o_rsp0_zero(rz0),
    .o_rsp1_valid(rv1), .i_rsp1_ready(rr[1]), .o_rsp1_data(rd1), .o_rsp1_zero(rz1),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_ctrl(alu_ctrl),
    .i_alu_out(alu_out), .i_alu_zero(alu_zero)
  );

  function automatic logic [31:0] alu_f(input logic [31:0] x, input logic [31:0] y, input logic [3:0] op);
    case (op)
      4'b0000: return x + y;
      4'b0010: return x - y;
      4'b0100: return x & y;
      4'b0110: return x | y;
      4'b1110: return x ^ y;
      4'b1000: return x << y[4:0];
      4'b1011: return x >> y[4:0];
      4'b1111: return $unsigned($signed(x) >>> y[4:0]);
      4'b1010: return {31'b0, $signed(x) < $signed(y)};
      4'b1100: return {31'b0, x < y};
      default: return 32'h0;
    endcase
  endfunction

  assign alu_out = alu_f(alu_a, alu_b, alu_ctrl);
  assign alu_zero = (alu_out == 32'h0);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction model: one operation in flight; response becomes visible in the
  // second cycle after the accepting edge and retires on the consumer's ready.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_ready", {rdy1, rdy0}, 0);
      check("rst_rsp_valid", {rv1, rv0}, 0);
      check("rst_alu", {alu_ctrl, alu_a | alu_b}, 0);
      m_busy = 0; m_last = 1; m_cnt = 0; m_id = 0; hs = 0;
      m_a = 0; m_b = 0; m_c = 0;
    end else begin
      g = (v == 2'b11) ? ~m_last : v[1];
      er = (!m_busy && v != 0) ? 2'b01 << g : 2'b00;
      ev = (m_busy && m_cnt) ? 2'b01 << m_id : 2'b00;
      check("req_ready", {rdy1, rdy0}, er);
      check("rsp_valid", {rv1, rv0}, ev);
      check("alu_operands", {alu_ctrl, alu_a, alu_b}, {m_c, m_a, m_b});
      if (ev != 0) begin
        check("rsp0_data", rd0, m_data);
        check("rsp1_data", rd1, m_data);
        check("rsp_zero", {rz1, rz0}, {2{m_data == 0}});
      end
      if (rdy0 | rdy1) q_gnt.push_back(rdy1);
      hs = er;
      if (er != 0) begin
        m_busy = 1; m_cnt = 0; m_id = g; m_last = g;
        m_a = req_a[g]; m_b = req_b[g]; m_c = req_c[g];
        m_data = alu_f(m_a, m_b, m_c);
      end else if (m_busy) begin
        if (m_cnt && rr[m_id]) begin
          m_busy = 0;
          q_res.push_back(m_id ? {rz1, rd1} : {rz0, rd0});
        end else m_cnt = 1;
      end
    end
  end

  task automatic set_op(input int n, input logic [31:0] x, input logic [31:0] y, input logic [3:0] op);
    req_a[n] = x; req_b[n] = y; req_c[n] = op; v[n] = 1'b1;
  endtask

  task automatic new_op(input int n);
    logic [31:0] x;
    x = $urandom;
    set_op(n, x, ($urandom_range(0, 3) == 0) ? x : $urandom,
           ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : codes[$urandom_range(0, 9)]);
  endtask

  // Drops each request once accepted, except the first n_keep acceptances reload a new op.
  task automatic serve(input int n_keep);
    int k = 0, t = 0;
    while ((v != 0 || m_busy) && t < 300) begin
      @(posedge clk); #1; t++;
      for (int n = 0; n < 2; n++)
        if (hs[n]) begin
          k++;
          if (k <= n_keep) new_op(n); else v[n] = 1'b0;
        end
    end
    check("serve_timeout", t >= 300, 0);
  endtask

  task automatic random_run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      rr = 2'($urandom);
      for (int n = 0; n < 2; n++)
        if (hs[n] || !v[n]) begin
          if ($urandom_range(0, 1) == 1) new_op(n); else v[n] = 1'b0;
        end else if ($urandom_range(0, 15) == 0) v[n] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1; v = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    rst = 1; v = 0; rr = 0; hs = 0;
    for (int n = 0; n < 2; n++) begin req_a[n] = 0; req_b[n] = 0; req_c[n] = 0; end
    repeat (3) @(posedge clk);
    #1 rst = 0;
    // single ADD on requester 0
    set_op(0, 5, 3, 4'b0000); rr = 2'b11;
    @(negedge clk); check("single_ready0", rdy0, 1); check("single_ready1", rdy1, 0);
    @(posedge clk); #1 v[0] = 0;
    @(negedge clk); check("single_exec_rv", {rv1, rv0}, 0);
    @(negedge clk);
    check("single_rv0", rv0, 1); check("single_data", rd0, 8);
    check("single_zero", rz0, 0); check("single_rv1", rv1, 0);
    // tie right after reset: requester 0 first
    do_reset();
    q_gnt.delete(); q_res.delete();
    set_op(0, 7, 7, 4'b0010); set_op(1, 32'hFFFFFFFF, 1, 4'b1010);
    serve(0);
    check("tie_count", q_gnt.size() + q_res.size(), 4);
    if (q_gnt.size() == 2 && q_res.size() == 2) begin
      check("tie_first", q_gnt[0], 0); check("tie_second", q_gnt[1], 1);
      check("tie_res0", q_res[0], {1'b1, 32'h0}); check("tie_res1", q_res[1], {1'b0, 32'h1});
    end
    // six back-to-back contended operations alternate
    q_gnt.delete();
    new_op(0); new_op(1);
    serve(4);
    check("fair_count", q_gnt.size(), 6);
    foreach (q_gnt[i]) check("fair_order", q_gnt[i], i % 2);
    // response backpressure on requester 1 with requester 0 waiting
    rr = 2'b00; set_op(1, 32'h80000000, 4, 4'b1111);
    @(negedge clk); check("bp_grant1", rdy1, 1);
    @(posedge clk); #1 v[1] = 0; set_op(0, 32'h11, 32'h22, 4'b0000);
    @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      check("bp_rv1", rv1, 1); check("bp_data", rd1, 32'hF8000000);
      check("bp_zero", rz1, 0); check("bp_rdy0", rdy0, 0);
    end
    @(posedge clk); #1 rr = 2'b11;
    @(negedge clk); check("bp_rdy0_hs", rdy0, 0);
    @(negedge clk); check("bp_rdy0_after", rdy0, 1);
    serve(0);
    // reset during EXEC drops the operation
    set_op(0, 1, 2, 4'b0000);
    @(negedge clk); check("rx_grant", rdy0, 1);
    @(posedge clk); #1 v[0] = 0; rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (4) begin @(negedge clk); check("rx_no_rsp", {rv1, rv0}, 0); end
    q_res.delete();
    @(posedge clk); #1 set_op(1, 32'hF0, 32'hFF, 4'b1110);
    serve(0);
    check("rx_count", q_res.size(), 1);
    if (q_res.size() == 1) check("rx_data", q_res[0], {1'b0, 32'h0F});
    // undefined control code
    q_res.delete();
    set_op(0, 9, 9, 4'b0001);
    serve(0);
    check("ill_count", q_res.size(), 1);
    if (q_res.size() == 1) check("ill_data", q_res[0], {1'b1, 32'h0});
    // random traffic with cancellations and backpressure
    random_run(3000);
    @(posedge clk); #1 v = 0; rr = 2'b11;
    serve(0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
